// File: rtl/ps2_key_if.sv
// PS/2 keyboard pins plus the decoded key-event and held-key outputs.
// The keyboard side (master) drives the pins; the controller (slave) drives the events.
interface ps2_key_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       code_valid;
    logic       code_ext;
    logic       code_break;
    logic       frame_err;
    logic [4:0] p1_keys;
    logic [4:0] p2_keys;

    modport master (
        output ps2_clk, ps2_data,
        input  scancode, code_valid, code_ext, code_break, frame_err, p1_keys, p2_keys
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output scancode, code_valid, code_ext, code_break, frame_err, p1_keys, p2_keys
    );
endinterface

// File: rtl/ps2_key_controller.sv
// PS/2 receiver: frames 11-bit packets, resolves E0/F0 prefixes into key events and
// tracks the held state of both Bomberman players' keys.
//
// state  | meaning
// IDLE   | waiting for a start bit (data 0 on a PS/2 falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | checking odd parity over data + parity bit
// STOP   | checking the stop bit, then back to IDLE
module ps2_key_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    ps2_key_if.slave   bus
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       fall;
    logic       data_s;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end
    assign fall   = clk_prev & ~clk_sync[1];
    assign data_s = data_sync[1];

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic [7:0]    byte_q;
    logic          par_ok;
    logic          byte_done;
    logic          frame_err;
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            byte_q    <= 8'h00;
            par_ok    <= 1'b0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            if (state != IDLE && !fall && tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                tmo_cnt   <= '0;
            end else begin
                if (fall || state == IDLE) tmo_cnt <= '0;
                else                       tmo_cnt <= tmo_cnt + CW'(1);
                if (fall) begin
                    case (state)
                        IDLE: begin
                            if (!data_s) begin
                                state   <= DATA;
                                bit_cnt <= 3'd0;
                            end
                        end
                        DATA: begin
                            shift_reg <= {data_s, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= PARITY;
                        end
                        PARITY: begin
                            par_ok <= ^{shift_reg, data_s};
                            state  <= STOP;
                        end
                        STOP: begin
                            if (data_s && par_ok) begin
                                byte_done <= 1'b1;
                                byte_q    <= shift_reg;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    logic       ext_flag;
    logic       brk_flag;
    logic [7:0] scancode;
    logic       code_valid;
    logic       code_ext;
    logic       code_break;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            scancode   <= 8'h00;
            code_valid <= 1'b0;
            code_ext   <= 1'b0;
            code_break <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            if (byte_done) begin
                if (byte_q == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    scancode   <= byte_q;
                    code_ext   <= ext_flag;
                    code_break <= brk_flag;
                    code_valid <= 1'b1;
                    ext_flag   <= 1'b0;
                    brk_flag   <= 1'b0;
                end
            end else if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    // Bit order in both vectors: {bomb, right, left, down, up}.
    logic [4:0] p1_keys;
    logic [4:0] p2_keys;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            p1_keys <= 5'b0;
            p2_keys <= 5'b0;
        end else if (code_valid) begin
            case ({code_ext, scancode})
                9'h029: p1_keys[4] <= ~code_break;
                9'h023: p1_keys[3] <= ~code_break;
                9'h01C: p1_keys[2] <= ~code_break;
                9'h01B: p1_keys[1] <= ~code_break;
                9'h01D: p1_keys[0] <= ~code_break;
                9'h05A: p2_keys[4] <= ~code_break;
                9'h174: p2_keys[3] <= ~code_break;
                9'h16B: p2_keys[2] <= ~code_break;
                9'h172: p2_keys[1] <= ~code_break;
                9'h175: p2_keys[0] <= ~code_break;
                default: ;
            endcase
        end
    end

    assign bus.scancode   = scancode;
    assign bus.code_valid = code_valid;
    assign bus.code_ext   = code_ext;
    assign bus.code_break = code_break;
    assign bus.frame_err  = frame_err;
    assign bus.p1_keys    = p1_keys;
    assign bus.p2_keys    = p2_keys;
endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller: sends PS/2 frames and checks events and held keys.
module tb_ps2_key_controller;
    localparam int TMO  = 200;
    localparam int HALF = 10;

    logic clk;
    logic rst_n;
    ps2_key_if bus ();

    ps2_key_controller #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int cv_cyc = 0;
    int last_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.code_valid === 1'b1) begin
            cv_cnt = cv_cnt + 1;
            cv_cyc = cyc;
        end
        if (bus.frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic flip_par, input logic stop);
        logic [10:0] fr;
        fr = {stop, (~^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(fr[i]);
        bus.ps2_data = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        if (bus.scancode !== 8'h00 || bus.code_ext !== 1'b0 || bus.code_break !== 1'b0) begin
            $display("FAIL reset_event: got sc=%h ext=%b brk=%b want 00/0/0",
                     bus.scancode, bus.code_ext, bus.code_break);
            fails++;
        end
        tests++;
        if (bus.p1_keys !== 5'b0 || bus.p2_keys !== 5'b0) begin
            $display("FAIL reset_keys: got p1=%b p2=%b want 00000/00000", bus.p1_keys, bus.p2_keys);
            fails++;
        end
        tests++;
        if (cv_cnt !== 0 || fe_cnt !== 0) begin
            $display("FAIL reset_pulses: got cv=%0d fe=%0d want 0/0", cv_cnt, fe_cnt);
            fails++;
        end
        tests++;
    endtask

    task automatic test_make();
        int cv0, fe0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_byte(8'h1D, 1'b0, 1'b1);
        if (cv_cnt - cv0 !== 1 || fe_cnt - fe0 !== 0) begin
            $display("FAIL make_pulses: got cv=%0d fe=%0d want 1/0", cv_cnt - cv0, fe_cnt - fe0);
            fails++;
        end
        tests++;
        if (cv_cyc - last_fall_cyc !== 4) begin
            $display("FAIL make_latency: got %0d cycles want 4", cv_cyc - last_fall_cyc);
            fails++;
        end
        tests++;
        if (bus.scancode !== 8'h1D || bus.code_ext !== 1'b0 || bus.code_break !== 1'b0) begin
            $display("FAIL make_event: got sc=%h ext=%b brk=%b want 1d/0/0",
                     bus.scancode, bus.code_ext, bus.code_break);
            fails++;
        end
        tests++;
        if (bus.p1_keys !== 5'b00001 || bus.p2_keys !== 5'b0) begin
            $display("FAIL make_keys: got p1=%b p2=%b want 00001/00000", bus.p1_keys, bus.p2_keys);
            fails++;
        end
        tests++;
    endtask

    task automatic test_break();
        int cv0;
        cv0 = cv_cnt;
        send_byte(8'hF0, 1'b0, 1'b1);
        if (cv_cnt - cv0 !== 0 || bus.p1_keys !== 5'b00001) begin
            $display("FAIL break_prefix: got cv=%0d p1=%b want 0/00001", cv_cnt - cv0, bus.p1_keys);
            fails++;
        end
        tests++;
        send_byte(8'h1D, 1'b0, 1'b1);
        if (cv_cnt - cv0 !== 1 || bus.code_break !== 1'b1 || bus.scancode !== 8'h1D) begin
            $display("FAIL break_event: got cv=%0d brk=%b sc=%h want 1/1/1d",
                     cv_cnt - cv0, bus.code_break, bus.scancode);
            fails++;
        end
        tests++;
        if (bus.p1_keys !== 5'b00000) begin
            $display("FAIL break_keys: got p1=%b want 00000", bus.p1_keys);
            fails++;
        end
        tests++;
    endtask

    task automatic test_extended();
        int cv0;
        cv0 = cv_cnt;
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'h75, 1'b0, 1'b1);
        if (cv_cnt - cv0 !== 1 || bus.code_ext !== 1'b1 || bus.code_break !== 1'b0 ||
            bus.p2_keys !== 5'b00001) begin
            $display("FAIL ext_up: got cv=%0d ext=%b brk=%b p2=%b want 1/1/0/00001",
                     cv_cnt - cv0, bus.code_ext, bus.code_break, bus.p2_keys);
            fails++;
        end
        tests++;
        send_byte(8'h75, 1'b0, 1'b1);
        if (cv_cnt - cv0 !== 2 || bus.code_ext !== 1'b0 || bus.scancode !== 8'h75) begin
            $display("FAIL keypad_event: got cv=%0d ext=%b sc=%h want 2/0/75",
                     cv_cnt - cv0, bus.code_ext, bus.scancode);
            fails++;
        end
        tests++;
        if (bus.p2_keys !== 5'b00001 || bus.p1_keys !== 5'b00000) begin
            $display("FAIL keypad_keys: got p1=%b p2=%b want 00000/00001", bus.p1_keys, bus.p2_keys);
            fails++;
        end
        tests++;
    endtask

    task automatic test_parity_err();
        int cv0, fe0;
        send_byte(8'h1C, 1'b0, 1'b1);
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h1C, 1'b1, 1'b1);
        if (fe_cnt - fe0 !== 1 || cv_cnt - cv0 !== 0 || bus.p1_keys !== 5'b00100) begin
            $display("FAIL parity_err: got fe=%0d cv=%0d p1=%b want 1/0/00100",
                     fe_cnt - fe0, cv_cnt - cv0, bus.p1_keys);
            fails++;
        end
        tests++;
        // The error must have dropped the pending F0, so this is a make.
        send_byte(8'h1C, 1'b0, 1'b1);
        if (cv_cnt - cv0 !== 1 || bus.code_break !== 1'b0 || bus.p1_keys !== 5'b00100) begin
            $display("FAIL err_clears_prefix: got cv=%0d brk=%b p1=%b want 1/0/00100",
                     cv_cnt - cv0, bus.code_break, bus.p1_keys);
            fails++;
        end
        tests++;
    endtask

    task automatic test_stop_err();
        int cv0, fe0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_byte(8'h29, 1'b0, 1'b0);
        if (fe_cnt - fe0 !== 1 || cv_cnt - cv0 !== 0 || bus.p1_keys !== 5'b00100) begin
            $display("FAIL stop_err: got fe=%0d cv=%0d p1=%b want 1/0/00100",
                     fe_cnt - fe0, cv_cnt - cv0, bus.p1_keys);
            fails++;
        end
        tests++;
    endtask

    task automatic test_timeout();
        int cv0, fe0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
        repeat (TMO + 40) @(negedge clk);
        if (fe_cnt - fe0 !== 1 || cv_cnt - cv0 !== 0) begin
            $display("FAIL timeout_err: got fe=%0d cv=%0d want 1/0", fe_cnt - fe0, cv_cnt - cv0);
            fails++;
        end
        tests++;
        send_byte(8'h29, 1'b0, 1'b1);
        if (cv_cnt - cv0 !== 1 || fe_cnt - fe0 !== 1 || bus.p1_keys !== 5'b10100) begin
            $display("FAIL timeout_recover: got cv=%0d fe=%0d p1=%b want 1/1/10100",
                     cv_cnt - cv0, fe_cnt - fe0, bus.p1_keys);
            fails++;
        end
        tests++;
    endtask

    task automatic test_back_to_back();
        int cv0;
        cv0 = cv_cnt;
        send_byte(8'h23, 1'b0, 1'b1);
        send_byte(8'h1B, 1'b0, 1'b1);
        if (bus.p1_keys !== 5'b11110) begin
            $display("FAIL b2b_p1: got p1=%b want 11110", bus.p1_keys);
            fails++;
        end
        tests++;
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h75, 1'b0, 1'b1);
        if (bus.code_ext !== 1'b1 || bus.code_break !== 1'b1 || bus.p2_keys !== 5'b00000) begin
            $display("FAIL ext_break: got ext=%b brk=%b p2=%b want 1/1/00000",
                     bus.code_ext, bus.code_break, bus.p2_keys);
            fails++;
        end
        tests++;
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'h6B, 1'b0, 1'b1);
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'h6B, 1'b0, 1'b1);
        if (cv_cnt - cv0 !== 5 || bus.p2_keys !== 5'b00100 || bus.p1_keys !== 5'b11110) begin
            $display("FAIL typematic: got cv=%0d p2=%b p1=%b want 5/00100/11110",
                     cv_cnt - cv0, bus.p2_keys, bus.p1_keys);
            fails++;
        end
        tests++;
    endtask

    task automatic test_mid_reset();
        int cv0, fe0;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (bus.p1_keys !== 5'b0 || bus.p2_keys !== 5'b0 || bus.scancode !== 8'h00 ||
            bus.code_ext !== 1'b0 || bus.code_break !== 1'b0 ||
            bus.code_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            $display("FAIL midreset_outputs: got p1=%b p2=%b sc=%h ext=%b brk=%b want all 0",
                     bus.p1_keys, bus.p2_keys, bus.scancode, bus.code_ext, bus.code_break);
            fails++;
        end
        tests++;
        bus.ps2_data = 1'b1;
        bus.ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_byte(8'h1B, 1'b0, 1'b1);
        if (cv_cnt - cv0 !== 1 || fe_cnt - fe0 !== 0 || bus.p1_keys !== 5'b00010 ||
            bus.p2_keys !== 5'b0) begin
            $display("FAIL midreset_recover: got cv=%0d fe=%0d p1=%b p2=%b want 1/0/00010/00000",
                     cv_cnt - cv0, fe_cnt - fe0, bus.p1_keys, bus.p2_keys);
            fails++;
        end
        tests++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity_err();
        test_stop_err();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
